// File: rtl/geq_seq.sv
`default_nettype none
// ============================================================================
//  Module   : geq_seq
//  Summary  : Iterative unsigned magnitude comparator, MSB-first, CHUNK bits
//             per clock, start/busy/done handshake with eq/gt/lt result.
//             Optional macro GEQ_SEQ_EARLY_EXIT_EN ends the compare as soon as
//             the first differing chunk is found.
//  Revision : 1.0 - initial release
// ============================================================================
module geq_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;

`ifdef GEQ_SEQ_EARLY_EXIT_EN
    localparam bit c_early_exit = 1'b1;
`else
    localparam bit c_early_exit = 1'b0;
`endif

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("geq_seq: WIDTH must be >= 2 and an exact multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_decided;
    logic                 r_gt_int;
    logic                 r_eq;
    logic                 r_gt;
    logic                 r_lt;

    logic [CHUNK-1:0]     w_chunk_a;
    logic [CHUNK-1:0]     w_chunk_b;
    logic                 w_differ;
    logic                 w_a_gt;
    logic                 w_accept;
    logic                 w_last;

    assign w_chunk_a = r_a[WIDTH-1 -: CHUNK];
    assign w_chunk_b = r_b[WIDTH-1 -: CHUNK];
    // Only the first differing chunk counts; later ones are masked by r_decided.
    assign w_differ  = !r_decided && (w_chunk_a != w_chunk_b);
    assign w_a_gt    = (w_chunk_a > w_chunk_b);
    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_state == S_RUN) &&
                       ((r_cnt == '0) || (c_early_exit && w_differ));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_eq <= 1'b0;
                r_gt <= 1'b0;
                r_lt <= 1'b0;
            end else if (w_last) begin
                // Fold in the final chunk's outcome on the exit edge itself.
                r_eq <= !(r_decided || w_differ);
                r_gt <= r_decided ? r_gt_int  : (w_differ && w_a_gt);
                r_lt <= r_decided ? !r_gt_int : (w_differ && !w_a_gt);
            end
        end
    end

    // Operand shifters and chunk counter carry no reset: don't-care outside RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_cnt     <= c_cnt_w'(c_nchunk - 1);
            r_decided <= 1'b0;
            r_gt_int  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (w_differ) begin
                r_decided <= 1'b1;
                r_gt_int  <= w_a_gt;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule
`default_nettype wire
